// File: rtl/scan_seq16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : scan_seq16
// Brief  : 16-row scan sequencer driving a 4-to-16 decoder (blank, then dwell)
// Rev    : 1.0  initial release
// ============================================================================
module scan_seq16 #(
  parameter int unsigned DWELL_CYC = 8,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       stop,
  input  logic       oneshot,
  output logic [3:0] w,
  output logic       en,
  output logic       busy,
  output logic       row_done,
  output logic       frame_done
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_blank = 2'd1;
  localparam logic [1:0] c_drive = 2'd2;

  localparam logic [7:0] c_blank_load = 8'(BLANK_CYC - 1);
  localparam logic [7:0] c_dwell_load = 8'(DWELL_CYC - 1);
  localparam logic [3:0] c_last_row   = 4'd15;

  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_row;
  logic       r_en;
  logic       r_busy;
  logic       r_row_done;
  logic       r_frame_done;

  // The row register doubles as the decoder address, so w only moves when r_row does.
  assign w          = r_row;
  assign en         = r_en;
  assign busy       = r_busy;
  assign row_done   = r_row_done;
  assign frame_done = r_frame_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= c_idle;
      r_cnt        <= 8'd0;
      r_row        <= 4'd0;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_row_done   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_row_done   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (start && !stop) begin
            r_state <= c_blank;
            r_cnt   <= c_blank_load;
            r_row   <= 4'd0;
            r_busy  <= 1'b1;
          end
        end

        c_blank: begin
          if (stop) begin
            r_state <= c_idle;
            r_cnt   <= 8'd0;
            r_row   <= 4'd0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_cnt == 8'd0) begin
            r_state <= c_drive;
            r_cnt   <= c_dwell_load;
            r_en    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        c_drive: begin
          // Stop takes priority over row completion: an abort never pulses row_done.
          if (stop) begin
            r_state <= c_idle;
            r_cnt   <= 8'd0;
            r_row   <= 4'd0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_cnt == 8'd0) begin
            r_en       <= 1'b0;
            r_row_done <= 1'b1;
            r_row      <= r_row + 4'd1;
            if (r_row == c_last_row) begin
              r_frame_done <= 1'b1;
              if (oneshot) begin
                r_state <= c_idle;
                r_cnt   <= 8'd0;
                r_busy  <= 1'b0;
              end else begin
                r_state <= c_blank;
                r_cnt   <= c_blank_load;
              end
            end else begin
              r_state <= c_blank;
              r_cnt   <= c_blank_load;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        default: begin
          r_state <= c_idle;
          r_cnt   <= 8'd0;
          r_row   <= 4'd0;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scan_seq16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_scan_seq16
// Brief  : self-checking bench for scan_seq16 (vector table + due-cycle scoreboard)
// Rev    : 1.0  initial release
// ============================================================================
module tb_scan_seq16;

  typedef struct {
    bit         start;
    bit         stop;
    logic [7:0] exp;   // {w, en, busy, row_done, frame_done}
  } vec_t;

  typedef struct {
    int         due;
    int         sel;
    int         idx;
    logic [7:0] exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       stop;
  logic       oneshot;
  logic [3:0] w0, w1;
  logic       en0, en1, busy0, busy1, rd0, rd1, fd0, fd1;
  logic [7:0] pack0, pack1;

  int         cyc_cnt = 0;
  int         n_cmp   = 0;
  int         n_err   = 0;
  string      phase   = "init";
  logic [3:0] prev_w  = 4'd0;
  sb_t        sb_q[$];
  vec_t       vecs[8];

  assign pack0 = {w0, en0, busy0, rd0, fd0};
  assign pack1 = {w1, en1, busy1, rd1, fd1};

  scan_seq16 #(.DWELL_CYC(3), .BLANK_CYC(2)) dut0 (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .oneshot(oneshot),
    .w(w0), .en(en0), .busy(busy0), .row_done(rd0), .frame_done(fd0)
  );

  scan_seq16 #(.DWELL_CYC(1), .BLANK_CYC(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .oneshot(oneshot),
    .w(w1), .en(en1), .busy(busy1), .row_done(rd1), .frame_done(fd1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "time limit expired");
  end

  // Expected outputs in cycle c (c=1 is the cycle after the start-sampling edge).
  function automatic logic [7:0] model(input int c, input int b, input int p, input bit os);
    int         row;
    int         ph;
    logic [3:0] wv;
    logic       e;
    logic       rd;
    row = (c - 1) / p;
    ph  = (c - 1) % p;
    wv  = 4'(row % 16);
    e   = (ph >= b);
    rd  = (c > 1) && (ph == 0);
    if (os && c > 16 * p) begin
      rd = (c == 16 * p + 1);
      return {4'd0, 1'b0, 1'b0, rd, rd};
    end
    return {wv, e, 1'b1, rd, rd && (wv == 4'd0)};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got w=%0d en=%0b busy=%0b rd=%0b fd=%0b, want w=%0d en=%0b busy=%0b rd=%0b fd=%0b",
               name, act[7:4], act[3], act[2], act[1], act[0], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input bit s, input bit st, input bit os);
    start   = s;
    stop    = st;
    oneshot = os;
  endtask

  task automatic expect_out(input int sel, input int idx, input logic [7:0] e);
    sb_q.push_back('{due: cyc_cnt + 1, sel: sel, idx: idx, exp: e});
  endtask

  // Pop every entry due by now and compare; also watch that w never moves under en=1.
  task automatic drain();
    sb_t        e;
    logic [7:0] act;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc_cnt) begin
      e   = sb_q.pop_front();
      act = (e.sel == 0) ? pack0 : pack1;
      n_cmp++;
      if (e.due != cyc_cnt || act !== e.exp) begin
        n_err++;
        $display("FAIL %s[%0d] dut%0d cyc=%0d due=%0d: got w=%0d en=%0b busy=%0b rd=%0b fd=%0b, want w=%0d en=%0b busy=%0b rd=%0b fd=%0b",
                 phase, e.idx, e.sel, cyc_cnt, e.due, act[7:4], act[3], act[2], act[1], act[0],
                 e.exp[7:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
      end
    end
    if (w0 !== prev_w) begin
      n_cmp++;
      if (en0 !== 1'b0) begin
        n_err++;
        $display("FAIL w_change_en (%s): w %0d->%0d with en=%0b, want en=0", phase, prev_w, w0, en0);
      end
    end
    prev_w = w0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'h00};  // idle, nothing requested
    vecs[1] = '{1'b1, 1'b1, 8'h00};  // start+stop together: stop wins
    vecs[2] = '{1'b0, 1'b1, 8'h00};  // stop alone in idle
    vecs[3] = '{1'b1, 1'b0, 8'h04};  // start -> blank, busy
    vecs[4] = '{1'b0, 1'b0, 8'h04};  // second blank cycle
    vecs[5] = '{1'b0, 1'b0, 8'h0C};  // drive row 0
    vecs[6] = '{1'b0, 1'b1, 8'h00};  // stop mid-drive -> idle
    vecs[7] = '{1'b0, 1'b0, 8'h00};  // remains idle

    resetn = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    #3;
    check("reset_async_dut0", pack0, 8'h00);
    check("reset_async_dut1", pack1, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_held_dut0", pack0, 8'h00);
    resetn = 1'b1;
    prev_w = w0;

    phase = "table";
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].start, vecs[i].stop, 1'b1);
      expect_out(0, i, vecs[i].exp);
      tick();
    end

    phase = "oneshot";
    for (int k = 0; k < 85; k++) begin
      drive((k == 0) || (k == 40), 1'b0, 1'b1);
      expect_out(0, k, model(k + 1, 2, 5, 1'b1));
      tick();
    end

    phase = "continuous";
    for (int k = 0; k < 250; k++) begin
      drive(k == 0, 1'b0, 1'b0);
      expect_out(0, k, model(k + 1, 2, 5, 1'b0));
      tick();
    end
    drive(1'b0, 1'b1, 1'b0);
    expect_out(0, 250, 8'h00);
    tick();

    phase = "stop_row7";
    for (int k = 0; k < 42; k++) begin
      drive(k == 0, k == 40, 1'b1);
      expect_out(0, k, (k >= 40) ? 8'h00 : model(k + 1, 2, 5, 1'b1));
      tick();
    end

    phase = "reset_row9";
    for (int k = 0; k < 48; k++) begin
      drive(k == 0, 1'b0, 1'b1);
      expect_out(0, k, model(k + 1, 2, 5, 1'b1));
      tick();
    end
    #2;
    resetn = 1'b0;
    #1;
    check("reset_mid_row9_dut0", pack0, 8'h00);
    check("reset_mid_row9_dut1", pack1, 8'h00);
    @(posedge clk);
    #1;
    check("reset_hold_edge_dut0", pack0, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    prev_w = w0;

    phase = "restart_dual";
    for (int k = 0; k < 36; k++) begin
      drive(k == 0, 1'b0, 1'b1);
      expect_out(0, k, model(k + 1, 2, 5, 1'b1));
      expect_out(1, k, model(k + 1, 1, 2, 1'b1));
      tick();
    end
    drive(1'b0, 1'b1, 1'b1);
    expect_out(0, 36, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b1);
    tick();
    tick();

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d entries left, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
